// File: rtl/gf_pkg.sv
// gf_pkg: shared GF(2^8) types, constants and table builders.
//   gf8_t    : field element (polynomial basis, poly 0x11D)
//   gf_log_t : discrete log of a field element, range 0..254
//   gf_tab_t : 256 byte entries packed LSB-first (entry i at [8*i +: 8])
// The log/antilog tables are built at elaboration time from the generator
// alpha = 0x02, so the LUT modules carry no hand-typed constants.
package gf_pkg;

  typedef logic [7:0] gf8_t;
  typedef logic [7:0] gf_log_t;
  typedef logic [2047:0] gf_tab_t;

  localparam logic [8:0] GF_POLY  = 9'h11D;
  localparam logic [8:0] GF_ORDER = 9'd255;

  // Multiply by alpha (x) and reduce by the field polynomial.
  function automatic logic [8:0] gf_xtime(input logic [8:0] x);
    logic [8:0] y;
    y = {x[7:0], 1'b0};
    if (y[8]) y = y ^ GF_POLY;
    return y;
  endfunction

  // EXP[i] = alpha^i for i = 0..254; EXP[255] = 1 is never addressed.
  function automatic gf_tab_t gf_exp_table();
    gf_tab_t    t;
    logic [8:0] x;
    t = '0;
    x = 9'h001;
    for (int i = 0; i < 255; i++) begin
      t[i*8 +: 8] = x[7:0];
      x = gf_xtime(x);
    end
    t[255*8 +: 8] = 8'h01;
    return t;
  endfunction

  // LOG[alpha^i] = i; LOG[0] has no meaning and is left 0 (LOG[1] = 0 too).
  function automatic gf_tab_t gf_log_table();
    gf_tab_t    t;
    logic [8:0] x;
    t = '0;
    x = 9'h001;
    for (int i = 0; i < 255; i++) begin
      t[int'(x[7:0])*8 +: 8] = 8'(i);
      x = gf_xtime(x);
    end
    return t;
  endfunction

  // Sum of two logs modulo 255. The raw sum is at most 508, so one
  // conditional subtract is enough.
  function automatic gf_log_t gf_log_add(input gf_log_t la, input gf_log_t lb);
    logic [8:0] s;
    s = {1'b0, la} + {1'b0, lb};
    if (s >= GF_ORDER) s = s - GF_ORDER;
    return s[7:0];
  endfunction

endpackage

// File: rtl/gf_mul_log_pipe_if.sv
// gf_mul_log_pipe_if: operand and product valid/ready streams.
//   in_*  : operand pair stream (a, b, tag) into the multiplier
//   out_* : product stream (data, tag) out of the multiplier
//   slave  : multiplier side
//   master : environment side (operand source + product consumer)
interface gf_mul_log_pipe_if #(
  parameter int TAG_W = 4
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [7:0]       in_a_i;
  logic [7:0]       in_b_i;
  logic [TAG_W-1:0] in_tag_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [7:0]       out_data_o;
  logic [TAG_W-1:0] out_tag_o;

  modport slave (
    input  in_valid_i, in_a_i, in_b_i, in_tag_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_tag_o
  );

  modport master (
    output in_valid_i, in_a_i, in_b_i, in_tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_tag_o
  );
endinterface

// File: rtl/lut_exp.sv
// lut_exp: combinational antilog table, addr_i (log) -> data_o (element).
//   addr_i : log value 0..254 (255 maps to 1 but is never produced)
//   data_o : alpha^addr_i
module lut_exp
  import gf_pkg::*;
(
  input  gf_log_t addr_i,
  output gf8_t    data_o
);
  localparam gf_tab_t EXP_TAB = gf_exp_table();

  assign data_o = EXP_TAB[{addr_i, 3'b000} +: 8];
endmodule

// File: rtl/lut_rev.sv
// lut_rev: combinational log table, addr_i (field element) -> data_o (log).
//   addr_i : 8-bit field element
//   data_o : its discrete log base alpha; log(0) = log(1) = 0
module lut_rev
  import gf_pkg::*;
(
  input  gf8_t    addr_i,
  output gf_log_t data_o
);
  localparam gf_tab_t LOG_TAB = gf_log_table();

  assign data_o = LOG_TAB[{addr_i, 3'b000} +: 8];
endmodule

// File: rtl/gf_mul_log_pipe.sv
// gf_mul_log_pipe: 3-stage pipelined GF(2^8) multiplier (poly 0x11D) using
// log/antilog tables, valid/ready on both sides, tag carried with each pair.
//   clk_i : rising-edge clock
//   rst_i : synchronous active-high reset; drops everything in flight
//   bus   : slave modport of gf_mul_log_pipe_if (operand in, product out)
// Stages: S1 logs + zero flag, S2 log sum mod 255, S3 antilog (or 0).
// Each stage loads when its downstream slot is empty or draining, so the
// pipe runs at one pair per cycle and holds its output while stalled.
module gf_mul_log_pipe
  import gf_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input logic              clk_i,
  input logic              rst_i,
  gf_mul_log_pipe_if.slave bus
);

  // Per-operand log lookups
  gf8_t    op   [2];
  gf_log_t lg   [2];

  assign op[0] = bus.in_a_i;
  assign op[1] = bus.in_b_i;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_log
      lut_rev u_lut_rev (
        .addr_i (op[gi]),
        .data_o (lg[gi])
      );
    end
  endgenerate

  // Stage registers
  logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  gf_log_t          la_q, la_d, lb_q, lb_d, s_q, s_d;
  logic             zero1_q, zero1_d, zero2_q, zero2_d;
  logic [TAG_W-1:0] tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;
  gf8_t             data_q, data_d;

  logic rdy1, rdy2, rdy3;
  gf8_t exp_val;

  lut_exp u_lut_exp (
    .addr_i (s_q),
    .data_o (exp_val)
  );

  // Ready ripples back from the output through the stage valids.
  assign rdy3 = !v3_q || bus.out_ready_i;
  assign rdy2 = !v2_q || rdy3;
  assign rdy1 = !v1_q || rdy2;

  always_comb begin
    v1_d    = v1_q;
    la_d    = la_q;
    lb_d    = lb_q;
    zero1_d = zero1_q;
    tag1_d  = tag1_q;
    v2_d    = v2_q;
    s_d     = s_q;
    zero2_d = zero2_q;
    tag2_d  = tag2_q;
    v3_d    = v3_q;
    data_d  = data_q;
    tag3_d  = tag3_q;

    // S1: capture logs on an input transfer
    if (rdy1) begin
      v1_d = bus.in_valid_i;
      if (bus.in_valid_i) begin
        la_d    = lg[0];
        lb_d    = lg[1];
        zero1_d = (bus.in_a_i == 8'h00) || (bus.in_b_i == 8'h00);
        tag1_d  = bus.in_tag_i;
      end
    end

    // S2: log sum modulo the group order
    if (rdy2) begin
      v2_d = v1_q;
      if (v1_q) begin
        s_d     = gf_log_add(la_q, lb_q);
        zero2_d = zero1_q;
        tag2_d  = tag1_q;
      end
    end

    // S3: antilog; a zero operand has no log, so the flag forces 0
    if (rdy3) begin
      v3_d = v2_q;
      if (v2_q) begin
        data_d = zero2_q ? 8'h00 : exp_val;
        tag3_d = tag2_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q    <= 1'b0;
      la_q    <= '0;
      lb_q    <= '0;
      zero1_q <= 1'b0;
      tag1_q  <= '0;
      v2_q    <= 1'b0;
      s_q     <= '0;
      zero2_q <= 1'b0;
      tag2_q  <= '0;
      v3_q    <= 1'b0;
      data_q  <= '0;
      tag3_q  <= '0;
    end else begin
      v1_q    <= v1_d;
      la_q    <= la_d;
      lb_q    <= lb_d;
      zero1_q <= zero1_d;
      tag1_q  <= tag1_d;
      v2_q    <= v2_d;
      s_q     <= s_d;
      zero2_q <= zero2_d;
      tag2_q  <= tag2_d;
      v3_q    <= v3_d;
      data_q  <= data_d;
      tag3_q  <= tag3_d;
    end
  end

  assign bus.in_ready_o  = rdy1;
  assign bus.out_valid_o = v3_q;
  assign bus.out_data_o  = data_q;
  assign bus.out_tag_o   = tag3_q;

endmodule

// File: tb/tb_gf_mul_log_pipe.sv
// Testbench for gf_mul_log_pipe: directed vector table, stall/order and
// reset sequences, then randomized traffic checked against a shift-xor
// GF(2^8) multiply model through a FIFO scoreboard.
module tb_gf_mul_log_pipe;

  localparam int TAG_W = 4;
  localparam int N_RAND = 10000;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  always #5 clk_i = ~clk_i;

  gf_mul_log_pipe_if #(.TAG_W(TAG_W)) bus ();

  gf_mul_log_pipe #(.TAG_W(TAG_W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [7:0]       data;
    logic [TAG_W-1:0] tag;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] p;
    string      name;
  } vec_t;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];
  logic [TAG_W-1:0] tag_log[$];
  logic fired_in, fired_out;
  logic hold;
  logic [7:0] hold_data;
  logic [TAG_W-1:0] hold_tag;

  // Reference: carry-less shift-and-add multiply with reduction by 0x11D.
  function automatic logic [7:0] gf_mul_ref(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc, x;
    acc = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
    end
    return acc;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One clock cycle: account for handshakes seen before the edge, then
  // advance and check that a stalled output stayed put.
  task automatic tick();
    exp_t e;
    #1;
    fired_in  = bus.in_valid_i && bus.in_ready_o && !rst_i;
    fired_out = bus.out_valid_o && bus.out_ready_i && !rst_i;
    hold      = bus.out_valid_o && !bus.out_ready_i && !rst_i;
    hold_data = bus.out_data_o;
    hold_tag  = bus.out_tag_o;
    if (fired_out) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", int'(bus.out_data_o), int'(e.data));
        chk("out_tag", int'(bus.out_tag_o), int'(e.tag));
        tag_log.push_back(bus.out_tag_o);
      end
    end
    if (fired_in)
      exp_q.push_back('{data: gf_mul_ref(bus.in_a_i, bus.in_b_i), tag: bus.in_tag_i});
    @(posedge clk_i);
    #1;
    if (rst_i) exp_q.delete();
    if (hold) begin
      chk("hold_valid", int'(bus.out_valid_o), 1);
      chk("hold_data", int'(bus.out_data_o), int'(hold_data));
      chk("hold_tag", int'(bus.out_tag_o), int'(hold_tag));
    end
  endtask

  vec_t vecs[6];

  initial begin
    int idx;
    int sent;
    int cyc;
    int seen;

    vecs[0] = '{a: 8'h02, b: 8'h03, p: 8'h06, name: "mul_02_03"};
    vecs[1] = '{a: 8'h80, b: 8'h02, p: 8'h1D, name: "mul_80_02"};
    vecs[2] = '{a: 8'h8E, b: 8'h02, p: 8'h01, name: "mul_8E_02_wrap"};
    vecs[3] = '{a: 8'hFF, b: 8'hFF, p: 8'hE2, name: "mul_FF_FF"};
    vecs[4] = '{a: 8'h00, b: 8'h57, p: 8'h00, name: "mul_00_57"};
    vecs[5] = '{a: 8'h57, b: 8'h00, p: 8'h00, name: "mul_57_00"};

    bus.in_valid_i  = 1'b0;
    bus.in_a_i      = 8'h00;
    bus.in_b_i      = 8'h00;
    bus.in_tag_i    = '0;
    bus.out_ready_i = 1'b0;

    // Reset state
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    chk("rst_out_valid", int'(bus.out_valid_o), 0);
    chk("rst_out_data", int'(bus.out_data_o), 0);
    chk("rst_out_tag", int'(bus.out_tag_o), 0);
    chk("rst_in_ready", int'(bus.in_ready_o), 1);
    $display("reset: out_valid=%0d in_ready=%0d", bus.out_valid_o, bus.in_ready_o);

    // Directed vectors: latency exactly 3 cycles from accept
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid_i = 1'b1;
      bus.in_a_i     = vecs[i].a;
      bus.in_b_i     = vecs[i].b;
      bus.in_tag_i   = TAG_W'(i + 1);
      tick();
      chk({vecs[i].name, "_accept"}, int'(fired_in), 1);
      bus.in_valid_i = 1'b0;
      tick();
      chk({vecs[i].name, "_early"}, int'(bus.out_valid_o), 0);
      tick();
      chk({vecs[i].name, "_valid"}, int'(bus.out_valid_o), 1);
      chk(vecs[i].name, int'(bus.out_data_o), int'(vecs[i].p));
      $display("vec %s: a=%02h b=%02h -> %02h (want %02h)", vecs[i].name,
               vecs[i].a, vecs[i].b, bus.out_data_o, vecs[i].p);
      tick();
    end

    // Stall: tags 1..6 offered back-to-back with the output blocked
    tag_log.delete();
    bus.out_ready_i = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      bus.in_valid_i = 1'b1;
      bus.in_a_i     = 8'($urandom_range(0, 255));
      bus.in_b_i     = 8'($urandom_range(0, 255));
      bus.in_tag_i   = TAG_W'(idx + 1);
      tick();
      if (fired_in) idx++;
      $display("stall cycle %0d: accepted=%0d in_ready=%0d", c, idx, bus.in_ready_o);
    end
    #1;
    chk("full_accepts", idx, 3);
    chk("full_in_ready", int'(bus.in_ready_o), 0);
    chk("full_head_tag", int'(bus.out_tag_o), 1);
    bus.out_ready_i = 1'b1;
    cyc = 0;
    while ((idx < 6 || exp_q.size() != 0) && cyc < 40) begin
      if (idx < 6) begin
        bus.in_valid_i = 1'b1;
        bus.in_tag_i   = TAG_W'(idx + 1);
      end else begin
        bus.in_valid_i = 1'b0;
      end
      tick();
      if (fired_in) begin
        idx++;
        bus.in_a_i = 8'($urandom_range(0, 255));
        bus.in_b_i = 8'($urandom_range(0, 255));
      end
      cyc++;
    end
    bus.in_valid_i = 1'b0;
    chk("stall_drain_timeout", int'(cyc < 40), 1);
    chk("stall_count", tag_log.size(), 6);
    for (int i = 0; i < tag_log.size(); i++)
      chk("stall_order", int'(tag_log[i]), i + 1);
    $display("stall release: %0d tags out in order", tag_log.size());

    // Reset with two pairs in flight
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid_i = 1'b1;
      bus.in_a_i     = 8'h11 + 8'(i);
      bus.in_b_i     = 8'h22;
      bus.in_tag_i   = TAG_W'(9 + i);
      tick();
    end
    bus.in_valid_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("midrst_out_valid", int'(bus.out_valid_o), 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.out_valid_o) seen++;
    end
    chk("midrst_no_output", seen, 0);
    $display("mid-flight reset: outputs seen afterwards=%0d", seen);

    // Randomized traffic against the reference model
    sent = 0;
    cyc = 0;
    bus.in_valid_i = 1'b0;
    while ((sent < N_RAND || exp_q.size() != 0) && cyc < 60000) begin
      if (!bus.in_valid_i || fired_in) begin
        bus.in_valid_i = (sent < N_RAND) && ($urandom_range(0, 9) < 8);
        bus.in_a_i     = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
        bus.in_b_i     = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
        bus.in_tag_i   = TAG_W'($urandom_range(0, (1 << TAG_W) - 1));
      end
      bus.out_ready_i = ($urandom_range(0, 9) < 7);
      tick();
      if (fired_in) sent++;
      if (sent >= N_RAND && fired_in) bus.in_valid_i = 1'b0;
      cyc++;
    end
    chk("random_timeout", int'(cyc < 60000), 1);
    $display("random: sent=%0d cycles=%0d pending=%0d", sent, cyc, exp_q.size());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
